cfg_router: RTL and testbench

//  Parametrised successor to the single-target config macro: decodes wishbone-side commands to NUM_TGT target macros
//  (CTRL, RA0..RAn) and to a local bank of NUM_CFG config registers. Tracks one outstanding command with an FSM,
//  mux-returns read data/ack, and times out silent targets with an error response. Sits between the wishbone slave and
//  the CTRL/RAx macros.

---
 rtl/cfg_router_pkg.sv | 18 +
 rtl/cfg_router_addr_dec.sv | 32 +++
 rtl/cfg_router.sv | 212 +++++++++++++++++++++
 tb/tb_cfg_router.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_router_pkg.sv
// Shared definitions for the config router: FSM states, STATUS offset and error response patterns.
package cfg_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0]  STATUS_OFS = 4'hF;
  localparam logic [15:0] BAD_PAT    = 16'hBAD0;
  localparam logic [15:0] DEAD_PAT   = 16'hDEAD;

  function automatic logic [31:0] err_word(input logic [15:0] pat, input logic [7:0] seq);
    return {pat, 8'h00, seq};
  endfunction

endpackage

// File: rtl/cfg_router_addr_dec.sv
// Combinational region decoder: the local config region beats any target, and the lowest target index beats higher ones.
module cfg_router_addr_dec
  import cfg_router_pkg::*;
#(
  parameter int                       NUM_TGT   = 2,
  parameter logic [31:0]              ADDR_MASK = 32'hFFFF0000,
  parameter logic [31:0]              CFG_ADDR  = 32'h00000000,
  parameter logic [32*NUM_TGT-1:0]    TGT_ADDR  = {32'h00080000, 32'h00010000}
) (
  input  logic [31:0]        adr,
  output logic               cfg_hit,
  output logic [NUM_TGT-1:0] tgt_hit,
  output logic               miss
);

  always_comb begin
    cfg_hit = ((adr & ADDR_MASK) == (CFG_ADDR & ADDR_MASK));
    tgt_hit = '0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int i = NUM_TGT - 1; i >= 0; i--) begin
      if ((adr & ADDR_MASK) == (TGT_ADDR[32*i +: 32] & ADDR_MASK)) begin
        tgt_hit    = '0;
        tgt_hit[i] = 1'b1;
      end
    end
    if (cfg_hit) begin
      tgt_hit = '0;
    end
    miss = !cfg_hit && (tgt_hit == '0);
  end

endmodule

// File: rtl/cfg_router.sv
// Routes single wishbone-side commands to NUM_TGT target macros or a local config bank, one outstanding at a time.
//
// state   | meaning
// IDLE    | ready; a command strobe is accepted and decoded this cycle
// WAIT    | target command issued; waiting for its ack or the timeout
// RESP    | registered response (ack/data/err) presented for one cycle
module cfg_router
  import cfg_router_pkg::*;
#(
  parameter int                    NUM_TGT   = 2,
  parameter int                    NUM_CFG   = 4,
  parameter logic [32*NUM_CFG-1:0] CFG_INIT  = '0,
  parameter logic [31:0]           ADDR_MASK = 32'hFFFF0000,
  parameter logic [31:0]           CFG_ADDR  = 32'h00000000,
  parameter logic [32*NUM_TGT-1:0] TGT_ADDR  = {32'h00080000, 32'h00010000},
  parameter int                    TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cmd_val,
  input  logic [31:0]             wb_cmd_adr,
  input  logic                    wb_cmd_we,
  input  logic [3:0]              wb_cmd_sel,
  input  logic [31:0]             wb_cmd_dat,
  output logic                    wb_rd_ack,
  output logic [31:0]             wb_rd_dat,
  output logic                    wb_err,
  output logic [31:0]             cmd_adr,
  output logic                    cmd_we,
  output logic [3:0]              cmd_sel,
  output logic [31:0]             cmd_dat,
  output logic [NUM_TGT-1:0]      tgt_cmd_val,
  input  logic [NUM_TGT-1:0]      tgt_rd_ack,
  input  logic [32*NUM_TGT-1:0]   tgt_rd_dat,
  output logic [32*NUM_CFG-1:0]   cfg_out
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO_LIM = TMR_W'(TIMEOUT);

  state_e               state_q, state_d;
  logic [7:0]           seq_q, seq_d;
  logic                 tmo_q, tmo_d;
  logic                 ovr_q, ovr_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [NUM_TGT-1:0]   tgt_oh_q, tgt_oh_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic                 err_q, err_d;
  logic [31:0]          cfg_q [NUM_CFG];
  logic [31:0]          cfg_d [NUM_CFG];

  logic                 cfg_hit;
  logic                 dec_miss;
  logic [NUM_TGT-1:0]   tgt_hit;
  logic [3:0]           cfg_idx;
  logic [31:0]          sel_dat;

  cfg_router_addr_dec #(
    .NUM_TGT   (NUM_TGT),
    .ADDR_MASK (ADDR_MASK),
    .CFG_ADDR  (CFG_ADDR),
    .TGT_ADDR  (TGT_ADDR)
  ) u_dec (
    .adr     (wb_cmd_adr),
    .cfg_hit (cfg_hit),
    .tgt_hit (tgt_hit),
    .miss    (dec_miss)
  );

  assign cfg_idx   = wb_cmd_adr[5:2];
  assign cmd_adr   = wb_cmd_adr;
  assign cmd_we    = wb_cmd_we;
  assign cmd_sel   = wb_cmd_sel;
  assign cmd_dat   = wb_cmd_dat;
  assign wb_rd_ack = ack_q;
  assign wb_rd_dat = dat_q;
  assign wb_err    = err_q;

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_TGT; i++) begin
      if (tgt_oh_q[i]) begin
        sel_dat = sel_dat | tgt_rd_dat[32*i +: 32];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CFG; i++) begin
      cfg_out[32*i +: 32] = cfg_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    tmo_d       = tmo_q;
    ovr_d       = ovr_q;
    tmr_d       = tmr_q;
    tgt_oh_d    = tgt_oh_q;
    ack_d       = 1'b0;
    dat_d       = '0;
    err_d       = 1'b0;
    tgt_cmd_val = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      cfg_d[i] = cfg_q[i];
    end

    case (state_q)
      ST_IDLE: begin
        if (wb_cmd_val) begin
          seq_d = seq_q + 8'd1;
          if (cfg_hit) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            if (wb_cmd_we) begin
              for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_idx == 4'(i)) begin
                  for (int b = 0; b < 4; b++) begin
                    if (wb_cmd_sel[b]) begin
                      cfg_d[i][8*b +: 8] = wb_cmd_dat[8*b +: 8];
                    end
                  end
                end
              end
              if (cfg_idx == STATUS_OFS) begin
                tmo_d = 1'b0;
                ovr_d = 1'b0;
              end
            end else if (cfg_idx == STATUS_OFS) begin
              // seq reported includes the STATUS read itself
              dat_d = {22'b0, ovr_q, tmo_q, seq_d};
            end else begin
              for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_idx == 4'(i)) begin
                  dat_d = cfg_q[i];
                end
              end
            end
          end else if (dec_miss) begin
            state_d = ST_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            dat_d   = err_word(BAD_PAT, seq_d);
          end else begin
            tgt_cmd_val = tgt_hit;
            tgt_oh_d    = tgt_hit;
            tmr_d       = '0;
            state_d     = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wb_cmd_val) begin
          ovr_d = 1'b1;
        end
        if ((tgt_rd_ack & tgt_oh_q) != '0) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          dat_d   = sel_dat;
        end else if (tmr_q == TMO_LIM) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          dat_d   = err_word(DEAD_PAT, seq_q);
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (wb_cmd_val) begin
          ovr_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      seq_q    <= '0;
      tmo_q    <= 1'b0;
      ovr_q    <= 1'b0;
      tmr_q    <= '0;
      tgt_oh_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= CFG_INIT[32*i +: 32];
      end
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      tmo_q    <= tmo_d;
      ovr_q    <= ovr_d;
      tmr_q    <= tmr_d;
      tgt_oh_q <= tgt_oh_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cfg_router.sv
// Directed bench for cfg_router: a transaction-level model predicts per-cycle acks, strobes and config contents.
module tb_cfg_router;

  localparam int TIMEOUT = 8;
  localparam logic [127:0] INIT = {32'h3333_3333, 32'h2222_2222, 32'h0033_0044, 32'h1111_1111};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wb_cmd_val = 1'b0;
  logic [31:0]  wb_cmd_adr = '0;
  logic         wb_cmd_we = 1'b0;
  logic [3:0]   wb_cmd_sel = '0;
  logic [31:0]  wb_cmd_dat = '0;
  logic         wb_rd_ack;
  logic [31:0]  wb_rd_dat;
  logic         wb_err;
  logic [31:0]  cmd_adr;
  logic         cmd_we;
  logic [3:0]   cmd_sel;
  logic [31:0]  cmd_dat;
  logic [1:0]   tgt_cmd_val;
  logic [1:0]   tgt_rd_ack = '0;
  logic [63:0]  tgt_rd_dat = '0;
  logic [127:0] cfg_out;

  cfg_router #(
    .NUM_TGT (2), .NUM_CFG (4), .CFG_INIT (INIT),
    .ADDR_MASK (32'hFFFF0000), .CFG_ADDR (32'h00000000),
    .TGT_ADDR ({32'h00080000, 32'h00010000}), .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk), .rst (rst),
    .wb_cmd_val (wb_cmd_val), .wb_cmd_adr (wb_cmd_adr), .wb_cmd_we (wb_cmd_we),
    .wb_cmd_sel (wb_cmd_sel), .wb_cmd_dat (wb_cmd_dat),
    .wb_rd_ack (wb_rd_ack), .wb_rd_dat (wb_rd_dat), .wb_err (wb_err),
    .cmd_adr (cmd_adr), .cmd_we (cmd_we), .cmd_sel (cmd_sel), .cmd_dat (cmd_dat),
    .tgt_cmd_val (tgt_cmd_val), .tgt_rd_ack (tgt_rd_ack), .tgt_rd_dat (tgt_rd_dat),
    .cfg_out (cfg_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  bit ea_now;

  // model state
  logic [31:0] m_cfg [4];
  logic [7:0]  m_seq;
  bit          m_tmo, m_ovr;
  int          pend_start, pend_i;
  logic [7:0]  pend_seq;

  // per-cycle expectations, keyed by cycle number
  bit          exp_ack  [int];
  bit          exp_err  [int];
  bit          exp_dchk [int];
  logic [31:0] exp_dat  [int];
  logic [1:0]  exp_tgt  [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] m_pack();
    return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = INIT[32*i +: 32];
    m_seq = 8'd0;
    m_tmo = 1'b0;
    m_ovr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      ea_now = exp_ack.exists(cyc);
      chk("wb_rd_ack", 128'(wb_rd_ack), 128'(ea_now));
      if (ea_now) begin
        chk("wb_err", 128'(wb_err), 128'(exp_err[cyc]));
        if (exp_dchk[cyc]) chk("wb_rd_dat", 128'(wb_rd_dat), 128'(exp_dat[cyc]));
      end
      chk("tgt_cmd_val", 128'(tgt_cmd_val), 128'(exp_tgt.exists(cyc) ? exp_tgt[cyc] : 2'b00));
      chk("cfg_out", cfg_out, m_pack());
      chk("cmd_pass", 128'({cmd_adr, cmd_we, cmd_sel, cmd_dat}),
          128'({wb_cmd_adr, wb_cmd_we, wb_cmd_sel, wb_cmd_dat}));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one command while the router is idle; returns at the cycle after the strobe.
  task automatic cmd(input logic [31:0] adr, input logic we, input logic [3:0] sel, input logic [31:0] dat);
    int c;
    int idx;
    c = cyc;
    m_seq = m_seq + 8'd1;
    idx = int'(adr[5:2]);
    if (adr[31:16] == 16'h0000) begin
      exp_ack[c+1] = 1'b1;
      exp_err[c+1] = 1'b0;
      exp_dchk[c+1] = !we;
      if (idx == 15)     exp_dat[c+1] = {22'b0, m_ovr, m_tmo, m_seq};
      else if (idx < 4)  exp_dat[c+1] = m_cfg[idx];
      else               exp_dat[c+1] = 32'h0;
    end else if (adr[31:16] == 16'h0001 || adr[31:16] == 16'h0008) begin
      pend_i     = (adr[31:16] == 16'h0001) ? 0 : 1;
      pend_start = c;
      pend_seq   = m_seq;
      exp_tgt[c] = 2'(1 << pend_i);
    end else begin
      exp_ack[c+1] = 1'b1;
      exp_err[c+1] = 1'b1;
      exp_dchk[c+1] = 1'b1;
      exp_dat[c+1] = {16'hBAD0, 8'h00, m_seq};
    end
    wb_cmd_val = 1'b1; wb_cmd_adr = adr; wb_cmd_we = we; wb_cmd_sel = sel; wb_cmd_dat = dat;
    step();
    wb_cmd_val = 1'b0; wb_cmd_we = 1'b0;
    if (adr[31:16] == 16'h0000 && we) begin
      if (idx < 4)
        for (int b = 0; b < 4; b++) if (sel[b]) m_cfg[idx][8*b +: 8] = dat[8*b +: 8];
      if (idx == 15) begin
        m_tmo = 1'b0;
        m_ovr = 1'b0;
      end
    end
  endtask

  // Pending target answers on the current cycle; it has TIMEOUT+1 waiting cycles to do so.
  task automatic tgt_answer(input logic [31:0] d);
    if (cyc <= pend_start + 1 + TIMEOUT) begin
      exp_ack[cyc+1] = 1'b1;
      exp_err[cyc+1] = 1'b0;
      exp_dchk[cyc+1] = 1'b1;
      exp_dat[cyc+1] = d;
    end
    tgt_rd_ack[pend_i] = 1'b1;
    tgt_rd_dat[32*pend_i +: 32] = d;
    step();
    tgt_rd_ack = '0;
  endtask

  task automatic lit_resp(input string name, input logic err, input logic [31:0] d);
    @(negedge clk);
    chk({name, "_ack"}, 128'(wb_rd_ack), 128'(1'b1));
    chk({name, "_err"}, 128'(wb_err), 128'(err));
    chk({name, "_dat"}, 128'(wb_rd_dat), 128'(d));
    step();
  endtask

  initial begin
    m_reset();
    step(2);
    chk_on = 1'b1;
    rst = 1'b0;
    step();
    chk("lit_reset_cfg", cfg_out, INIT);
    chk("lit_reset_dat", 128'({wb_rd_ack, wb_err, wb_rd_dat}), 128'(0));

    // write with byte enables, then a target read with a stray ack, then unmapped
    cmd(32'h0000_0004, 1'b1, 4'b0101, 32'hA5A5A5A5);
    lit_resp("lit_wr", 1'b0, wb_rd_dat);
    chk("lit_cfg1", 128'(cfg_out[63:32]), 128'(32'h00A500A5));
    cmd(32'h0008_0010, 1'b0, 4'hF, 32'h0);
    step();
    tgt_rd_ack[0] = 1'b1; tgt_rd_dat[31:0] = 32'hFFFF_FFFF;
    step();
    tgt_rd_ack = '0;
    tgt_answer(32'h0000_1234);
    lit_resp("lit_tgt1", 1'b0, 32'h0000_1234);
    cmd(32'h0040_0000, 1'b0, 4'hF, 32'h0);
    lit_resp("lit_unmapped", 1'b1, 32'hBAD0_0003);

    // local reads: register, reset value, out-of-bank offset, STATUS
    cmd(32'h0000_0004, 1'b0, 4'hF, 32'h0);  step();
    cmd(32'h0000_0008, 1'b0, 4'hF, 32'h0);  step();
    cmd(32'h0000_0020, 1'b0, 4'hF, 32'h0);  step();
    cmd(32'h0000_003C, 1'b0, 4'hF, 32'h0);
    lit_resp("lit_status0", 1'b0, 32'h0000_0007);

    // target 0 answers on the very last waiting cycle: ack beats expiry
    cmd(32'h0001_ABCD, 1'b0, 4'hF, 32'h0);
    step(TIMEOUT);
    tgt_answer(32'hCAFE_0008);
    lit_resp("lit_edge", 1'b0, 32'hCAFE_0008);

    // reset, then silent target with a dropped command during WAIT
    rst = 1'b1;
    step();
    m_reset();
    rst = 1'b0;
    step();
    cmd(32'h0001_0000, 1'b0, 4'hF, 32'h0);
    exp_ack[pend_start+TIMEOUT+2] = 1'b1;
    exp_err[pend_start+TIMEOUT+2] = 1'b1;
    exp_dchk[pend_start+TIMEOUT+2] = 1'b1;
    exp_dat[pend_start+TIMEOUT+2] = {16'hDEAD, 8'h00, pend_seq};
    step(2);
    wb_cmd_val = 1'b1; wb_cmd_adr = 32'h0008_0000;
    step();
    wb_cmd_val = 1'b0;
    m_ovr = 1'b1;
    m_tmo = 1'b1;
    while (cyc < pend_start + TIMEOUT + 2) step();
    lit_resp("lit_timeout", 1'b1, 32'hDEAD_0001);
    cmd(32'h0000_003C, 1'b0, 4'hF, 32'h0);
    lit_resp("lit_status1", 1'b0, 32'h0000_0302);
    cmd(32'h0000_003C, 1'b1, 4'hF, 32'hFFFF_FFFF);  step();
    cmd(32'h0000_003C, 1'b0, 4'hF, 32'h0);
    lit_resp("lit_status2", 1'b0, 32'h0000_0004);

    // reset while waiting on a target abandons it silently
    cmd(32'h0000_0000, 1'b1, 4'hF, 32'hFFFF_FFFF);  step();
    cmd(32'h0008_0000, 1'b0, 4'hF, 32'h0);
    step();
    rst = 1'b1;
    step();
    m_reset();
    rst = 1'b0;
    chk("lit_rst_wait_cfg", cfg_out, INIT);
    step();
    cmd(32'h0040_0000, 1'b0, 4'hF, 32'h0);
    lit_resp("lit_after_rst", 1'b1, 32'hBAD0_0001);
    step(3);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
